// File: rtl/p7_exec_cp0_unit_pkg.sv
// Shared constants for the E-stage ALU, the D-stage branch comparator and the M-stage CP0.
// Op codes, exception codes and CP0 register numbers live here so that RTL and bench agree.
package p7_exec_cp0_unit_pkg;

    localparam int unsigned DataWidth = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_OR   = 4'd2,
        ALU_AND  = 4'd3,
        ALU_LUI  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_XOR  = 4'd10,
        ALU_NOR  = 4'd11,
        ALU_SLLV = 4'd12,
        ALU_SRLV = 4'd13,
        ALU_SRAV = 4'd14
    } aluOp_e;

    typedef enum logic [2:0] {
        CMP_BEQ  = 3'd0,
        CMP_BNE  = 3'd1,
        CMP_BLEZ = 3'd2,
        CMP_BGTZ = 3'd3,
        CMP_BLTZ = 3'd4,
        CMP_BGEZ = 3'd5
    } cmpOp_e;

    localparam logic [2:0] NPC_PC4 = 3'b000;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;

endpackage

// File: rtl/p7_exec_cp0_unit_if.sv
// Signal bundle for the ALU, branch comparator and CP0 ports of p7_exec_cp0_unit.
// The pipeline side is the master; the execution unit is the slave.
interface p7_exec_cp0_unit_if;
    import p7_exec_cp0_unit_pkg::*;

    logic [3:0]           alu_op;
    logic [DataWidth-1:0] alu_in1;
    logic [DataWidth-1:0] alu_in2;
    logic [4:0]           alu_shamt;
    logic                 alu_calc;
    logic                 alu_ovchk;
    logic                 alu_load;
    logic                 alu_store;
    logic [DataWidth-1:0] alu_out;
    logic                 alu_ov;
    logic                 alu_adel;
    logic                 alu_ades;

    logic [DataWidth-1:0] cmp_a;
    logic [DataWidth-1:0] cmp_b;
    logic [2:0]           cmp_op;
    logic                 cmp_branch;
    logic [2:0]           cmp_npcop_in;
    logic [2:0]           cmp_npcop_out;

    logic                 cp0_we;
    logic [4:0]           cp0_addr;
    logic [DataWidth-1:0] cp0_wdata;
    logic [DataWidth-1:0] cp0_rdata;
    logic [DataWidth-1:0] cp0_vpc;
    logic                 cp0_bd;
    logic [4:0]           cp0_exccode;
    logic [5:0]           cp0_hwint;
    logic                 cp0_exlclr;
    logic [DataWidth-1:0] cp0_epc;
    logic                 cp0_req;

    modport master (
        output alu_op, alu_in1, alu_in2, alu_shamt, alu_calc, alu_ovchk, alu_load, alu_store,
        input  alu_out, alu_ov, alu_adel, alu_ades,
        output cmp_a, cmp_b, cmp_op, cmp_branch, cmp_npcop_in,
        input  cmp_npcop_out,
        output cp0_we, cp0_addr, cp0_wdata, cp0_vpc, cp0_bd, cp0_exccode, cp0_hwint, cp0_exlclr,
        input  cp0_rdata, cp0_epc, cp0_req
    );

    modport slave (
        input  alu_op, alu_in1, alu_in2, alu_shamt, alu_calc, alu_ovchk, alu_load, alu_store,
        output alu_out, alu_ov, alu_adel, alu_ades,
        input  cmp_a, cmp_b, cmp_op, cmp_branch, cmp_npcop_in,
        output cmp_npcop_out,
        input  cp0_we, cp0_addr, cp0_wdata, cp0_vpc, cp0_bd, cp0_exccode, cp0_hwint, cp0_exlclr,
        output cp0_rdata, cp0_epc, cp0_req
    );

endinterface

// File: rtl/p7_exec_cp0_unit_cp0_regs.sv
// CP0 status/cause/EPC registers plus the interrupt/exception request that flushes the pipeline.
// Holds all architectural state of the execution unit.
module p7_exec_cp0_unit_cp0_regs
    import p7_exec_cp0_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we_i,
    input  logic [4:0]           addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [DataWidth-1:0] vpc_i,
    input  logic                 bd_i,
    input  logic [4:0]           exccode_i,
    input  logic [5:0]           hwint_i,
    input  logic                 exlclr_i,
    output logic [DataWidth-1:0] rdata_o,
    output logic [DataWidth-1:0] epc_o,
    output logic                 req_o
);

    logic [5:0]           im_q, im_d;
    logic                 exl_q, exl_d;
    logic                 ie_q, ie_d;
    logic                 bd_q, bd_d;
    logic [5:0]           ip_q, ip_d;
    logic [4:0]           excCode_q, excCode_d;
    logic [DataWidth-1:0] epc_q, epc_d;

    logic                 intReq;
    logic                 excReq;
    logic [4:0]           chosenCode;
    logic [DataWidth-1:0] pcAligned;
    logic [DataWidth-1:0] srView;
    logic [DataWidth-1:0] causeView;
    logic                 unusedBits;

    assign unusedBits = ^{wdata_i[31:16], wdata_i[9:2], vpc_i[1:0]};

    // Interrupts outrank synchronous exceptions; both are masked while EXL is set.
    assign intReq     = (|(hwint_i & im_q)) & ie_q & ~exl_q;
    assign excReq     = (exccode_i != EXC_INT) & ~exl_q;
    assign req_o      = intReq | excReq;
    assign chosenCode = intReq ? EXC_INT : exccode_i;
    assign pcAligned  = {vpc_i[31:2], 2'b00};

    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        excCode_d = excCode_q;
        epc_d     = epc_q;
        ip_d      = hwint_i;
        if (req_o) begin
            exl_d     = 1'b1;
            bd_d      = bd_i;
            excCode_d = chosenCode;
            epc_d     = bd_i ? (pcAligned - 32'd4) : pcAligned;
        end else begin
            if (exlclr_i) begin
                exl_d = 1'b0;
            end
            // A same-cycle mtc0 to SR overrides the eret clear of EXL.
            if (we_i && addr_i == CP0_SR) begin
                im_d  = wdata_i[15:10];
                exl_d = wdata_i[1];
                ie_d  = wdata_i[0];
            end
            if (we_i && addr_i == CP0_EPC) begin
                epc_d = wdata_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q      <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= '0;
            excCode_q <= '0;
            epc_q     <= '0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            excCode_q <= excCode_d;
            epc_q     <= epc_d;
        end
    end

    assign srView    = {16'b0, im_q, 8'b0, exl_q, ie_q};
    assign causeView = {bd_q, 15'b0, ip_q, 3'b0, excCode_q, 2'b0};

    always_comb begin
        rdata_o = '0;
        case (addr_i)
            CP0_SR:    rdata_o = srView;
            CP0_CAUSE: rdata_o = causeView;
            CP0_EPC:   rdata_o = epc_q;
            default:   rdata_o = '0;
        endcase
    end

    assign epc_o = epc_q;

endmodule

// File: rtl/p7_exec_cp0_unit.sv
// Execution/exception block of the pipelined MIPS core: E-stage ALU with overflow/address traps,
// D-stage branch comparator, and the M-stage CP0 that raises the flush/redirect request.
module p7_exec_cp0_unit
    import p7_exec_cp0_unit_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    p7_exec_cp0_unit_if.slave   bus
);

    logic [DataWidth:0]   sum33;
    logic [DataWidth:0]   diff33;
    logic                 ovAdd;
    logic                 ovSub;
    logic                 ovSel;
    logic [DataWidth-1:0] aluResult;
    logic                 cmpCond;

    // Overflow is judged on a 33-bit sign-extended result: the top two bits disagree.
    assign sum33  = {bus.alu_in1[31], bus.alu_in1} + {bus.alu_in2[31], bus.alu_in2};
    assign diff33 = {bus.alu_in1[31], bus.alu_in1} - {bus.alu_in2[31], bus.alu_in2};
    assign ovAdd  = sum33[32] ^ sum33[31];
    assign ovSub  = diff33[32] ^ diff33[31];

    always_comb begin
        aluResult = '0;
        ovSel     = 1'b0;
        case (bus.alu_op)
            ALU_ADD:  begin aluResult = sum33[31:0];  ovSel = ovAdd; end
            ALU_SUB:  begin aluResult = diff33[31:0]; ovSel = ovSub; end
            ALU_OR:   aluResult = bus.alu_in1 | bus.alu_in2;
            ALU_AND:  aluResult = bus.alu_in1 & bus.alu_in2;
            ALU_LUI:  aluResult = bus.alu_in2 << 16;
            ALU_SLT:  aluResult = {31'b0, $signed(bus.alu_in1) < $signed(bus.alu_in2)};
            ALU_SLTU: aluResult = {31'b0, bus.alu_in1 < bus.alu_in2};
            ALU_SLL:  aluResult = bus.alu_in2 << bus.alu_shamt;
            ALU_SRL:  aluResult = bus.alu_in2 >> bus.alu_shamt;
            ALU_SRA:  aluResult = $unsigned($signed(bus.alu_in2) >>> bus.alu_shamt);
            ALU_XOR:  aluResult = bus.alu_in1 ^ bus.alu_in2;
            ALU_NOR:  aluResult = ~(bus.alu_in1 | bus.alu_in2);
            ALU_SLLV: aluResult = bus.alu_in2 << bus.alu_in1[4:0];
            ALU_SRLV: aluResult = bus.alu_in2 >> bus.alu_in1[4:0];
            ALU_SRAV: aluResult = $unsigned($signed(bus.alu_in2) >>> bus.alu_in1[4:0]);
            default:  aluResult = '0;
        endcase
    end

    assign bus.alu_out  = aluResult;
    assign bus.alu_ov   = bus.alu_calc & bus.alu_ovchk & ovSel;
    assign bus.alu_adel = bus.alu_load & ovAdd;
    assign bus.alu_ades = bus.alu_store & ovAdd;

    always_comb begin
        cmpCond = 1'b0;
        case (bus.cmp_op)
            CMP_BEQ:  cmpCond = (bus.cmp_a == bus.cmp_b);
            CMP_BNE:  cmpCond = (bus.cmp_a != bus.cmp_b);
            CMP_BLEZ: cmpCond = bus.cmp_a[31] | (bus.cmp_a == '0);
            CMP_BGTZ: cmpCond = ~bus.cmp_a[31] & (bus.cmp_a != '0);
            CMP_BLTZ: cmpCond = bus.cmp_a[31];
            CMP_BGEZ: cmpCond = ~bus.cmp_a[31];
            default:  cmpCond = 1'b0;
        endcase
    end

    // An untaken branch falls through to PC+4; everything else keeps the decoder's choice.
    assign bus.cmp_npcop_out = (bus.cmp_branch && !cmpCond) ? NPC_PC4 : bus.cmp_npcop_in;

    p7_exec_cp0_unit_cp0_regs uCp0Regs (
        .clk       (clk),
        .reset     (reset),
        .we_i      (bus.cp0_we),
        .addr_i    (bus.cp0_addr),
        .wdata_i   (bus.cp0_wdata),
        .vpc_i     (bus.cp0_vpc),
        .bd_i      (bus.cp0_bd),
        .exccode_i (bus.cp0_exccode),
        .hwint_i   (bus.cp0_hwint),
        .exlclr_i  (bus.cp0_exlclr),
        .rdata_o   (bus.cp0_rdata),
        .epc_o     (bus.cp0_epc),
        .req_o     (bus.cp0_req)
    );

endmodule

// File: tb/tb_p7_exec_cp0_unit.sv
// Directed bench for p7_exec_cp0_unit: hand-computed ALU, comparator and CP0 vectors,
// each compared with an immediate assertion.
module tb_p7_exec_cp0_unit;
    import p7_exec_cp0_unit_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    p7_exec_cp0_unit_if bus ();

    p7_exec_cp0_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] shamt, input logic calc, input logic ovchk,
                                 input logic load, input logic store);
        bus.alu_op    = op;
        bus.alu_in1   = a;
        bus.alu_in2   = b;
        bus.alu_shamt = shamt;
        bus.alu_calc  = calc;
        bus.alu_ovchk = ovchk;
        bus.alu_load  = load;
        bus.alu_store = store;
        #1;
    endtask

    task automatic applyCmp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic branch, input logic [2:0] npcIn);
        bus.cmp_op       = op;
        bus.cmp_a        = a;
        bus.cmp_b        = b;
        bus.cmp_branch   = branch;
        bus.cmp_npcop_in = npcIn;
        #1;
    endtask

    task automatic readCp0(input string tag, input logic [4:0] addr, input logic [31:0] expected);
        bus.cp0_addr = addr;
        #1;
        checkOutput(tag, bus.cp0_rdata, expected);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.alu_op = '0; bus.alu_in1 = '0; bus.alu_in2 = '0; bus.alu_shamt = '0;
        bus.alu_calc = 1'b0; bus.alu_ovchk = 1'b0; bus.alu_load = 1'b0; bus.alu_store = 1'b0;
        bus.cmp_a = '0; bus.cmp_b = '0; bus.cmp_op = '0; bus.cmp_branch = 1'b0; bus.cmp_npcop_in = '0;
        bus.cp0_we = 1'b0; bus.cp0_addr = '0; bus.cp0_wdata = '0; bus.cp0_vpc = '0;
        bus.cp0_bd = 1'b0; bus.cp0_exccode = '0; bus.cp0_hwint = '0; bus.cp0_exlclr = 1'b0;

        #12;
        readCp0("rst_sr", CP0_SR, 32'h0);
        readCp0("rst_cause", CP0_CAUSE, 32'h0);
        readCp0("rst_epc", CP0_EPC, 32'h0);
        checkOutput("rst_req", {31'b0, bus.cp0_req}, 32'h0);
        reset = 1'b0;
        tick();

        applyStimulus(4'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("add_out", bus.alu_out, 32'h8000_0000);
        checkOutput("add_ov", {31'b0, bus.alu_ov}, 32'h1);
        checkOutput("add_adel_off", {31'b0, bus.alu_adel}, 32'h0);
        applyStimulus(4'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("load_adel", {31'b0, bus.alu_adel}, 32'h1);
        checkOutput("load_ov", {31'b0, bus.alu_ov}, 32'h0);
        applyStimulus(4'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("store_ades", {31'b0, bus.alu_ades}, 32'h1);
        applyStimulus(4'd0, 32'h0000_0010, 32'h0000_0020, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("add_noov", {bus.alu_out[28:0], bus.alu_ov, bus.alu_adel, bus.alu_ades}, {29'h30, 3'b000});
        applyStimulus(4'd1, 32'h8000_0000, 32'h1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("sub_out", bus.alu_out, 32'h7FFF_FFFF);
        checkOutput("sub_ov", {31'b0, bus.alu_ov}, 32'h1);
        applyStimulus(4'd9, 32'h0, 32'h8000_0000, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("sra", bus.alu_out, 32'hF800_0000);
        applyStimulus(4'd8, 32'h0, 32'h8000_0000, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("srl", bus.alu_out, 32'h0800_0000);
        applyStimulus(4'd6, 32'h1, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("sltu", bus.alu_out, 32'h1);
        applyStimulus(4'd5, 32'h1, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("slt", bus.alu_out, 32'h0);
        applyStimulus(4'd4, 32'h0, 32'h0000_1234, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lui", bus.alu_out, 32'h1234_0000);
        applyStimulus(4'd14, 32'h0000_0024, 32'h8000_0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("srav", bus.alu_out, 32'hF800_0000);
        applyStimulus(4'd11, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("nor", bus.alu_out, 32'hF0F0_FF0F);
        applyStimulus(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("op15", bus.alu_out, 32'h0);

        applyCmp(3'd3, 32'h0, 32'h0, 1'b1, 3'b001);
        checkOutput("bgtz_zero", {29'b0, bus.cmp_npcop_out}, 32'h0);
        applyCmp(3'd3, 32'h5, 32'h0, 1'b1, 3'b001);
        checkOutput("bgtz_pos", {29'b0, bus.cmp_npcop_out}, 32'h1);
        applyCmp(3'd0, 32'h7, 32'h7, 1'b1, 3'b001);
        checkOutput("beq_eq", {29'b0, bus.cmp_npcop_out}, 32'h1);
        applyCmp(3'd1, 32'h7, 32'h7, 1'b1, 3'b001);
        checkOutput("bne_eq", {29'b0, bus.cmp_npcop_out}, 32'h0);
        applyCmp(3'd2, 32'hFFFF_FFFF, 32'h0, 1'b1, 3'b001);
        checkOutput("blez_neg", {29'b0, bus.cmp_npcop_out}, 32'h1);
        applyCmp(3'd2, 32'h5, 32'h0, 1'b0, 3'b010);
        checkOutput("nonbranch", {29'b0, bus.cmp_npcop_out}, 32'h2);

        bus.cp0_we = 1'b1; bus.cp0_addr = CP0_SR; bus.cp0_wdata = 32'h0000_0401;
        tick();
        bus.cp0_we = 1'b0;
        readCp0("mtc0_sr", CP0_SR, 32'h0000_0401);
        bus.cp0_hwint = 6'b000001; bus.cp0_vpc = 32'h0000_1000;
        #1;
        checkOutput("int_req", {31'b0, bus.cp0_req}, 32'h1);
        tick();
        readCp0("int_cause", CP0_CAUSE, 32'h0000_0400);
        readCp0("int_sr", CP0_SR, 32'h0000_0403);
        checkOutput("int_epc", bus.cp0_epc, 32'h0000_1000);
        checkOutput("int_req_masked", {31'b0, bus.cp0_req}, 32'h0);

        bus.cp0_hwint = 6'b0; bus.cp0_exlclr = 1'b1;
        tick();
        bus.cp0_exlclr = 1'b0;
        readCp0("eret_sr", CP0_SR, 32'h0000_0401);

        bus.cp0_exccode = EXC_OV; bus.cp0_bd = 1'b1; bus.cp0_vpc = 32'h0000_3010;
        bus.cp0_we = 1'b1; bus.cp0_addr = CP0_EPC; bus.cp0_wdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("exc_req", {31'b0, bus.cp0_req}, 32'h1);
        tick();
        bus.cp0_we = 1'b0; bus.cp0_exccode = '0; bus.cp0_bd = 1'b0;
        checkOutput("exc_epc", bus.cp0_epc, 32'h0000_300C);
        readCp0("exc_cause", CP0_CAUSE, 32'h8000_0030);
        readCp0("exc_sr", CP0_SR, 32'h0000_0403);
        bus.cp0_exccode = EXC_ADEL;
        #1;
        checkOutput("exc_masked", {31'b0, bus.cp0_req}, 32'h0);
        bus.cp0_exccode = '0;

        bus.cp0_exlclr = 1'b1;
        tick();
        bus.cp0_exlclr = 1'b0;
        readCp0("exlclr_sr", CP0_SR, 32'h0000_0401);

        bus.cp0_exlclr = 1'b1; bus.cp0_we = 1'b1; bus.cp0_addr = CP0_SR; bus.cp0_wdata = 32'h0000_0403;
        tick();
        bus.cp0_exlclr = 1'b0; bus.cp0_we = 1'b0;
        readCp0("mtc0_wins", CP0_SR, 32'h0000_0403);
        bus.cp0_we = 1'b1; bus.cp0_addr = CP0_EPC; bus.cp0_wdata = 32'h1234_5678;
        tick();
        bus.cp0_we = 1'b0;
        checkOutput("mtc0_epc", bus.cp0_epc, 32'h1234_5678);
        readCp0("rd_other", 5'd5, 32'h0);

        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        readCp0("arst_sr", CP0_SR, 32'h0);
        readCp0("arst_cause", CP0_CAUSE, 32'h0);
        checkOutput("arst_epc", bus.cp0_epc, 32'h0);
        checkOutput("arst_req", {31'b0, bus.cp0_req}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus.cp0_we = 1'b1; bus.cp0_addr = CP0_CAUSE; bus.cp0_wdata = 32'hFFFF_FFFF;
        tick();
        bus.cp0_we = 1'b0;
        readCp0("cause_ro", CP0_CAUSE, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/p7_exec_cp0_unit.md
Name: p7_exec_cp0_unit

Overview:
- Bundles the three execution/exception primitives of the pipelined MIPS CPU: the E-stage ALU with exception detection, the D-stage branch comparator, and the M-stage CP0 coprocessor.
- The ALU and comparator are purely combinational; CP0 is the only state.
- CP0 produces `cp0_req`, which the pipeline uses to flush and redirect to the handler.

Parameters:
- `HANDLER_UNUSED`, none — the block has no parameters; all widths are fixed at 32 bits.

Ports:
- `clk` in 1 — clock, rising edge
- `reset` in 1 — asynchronous, active-high
- `alu_op` in 4 — ALU operation
- `alu_in1` in 32 — operand A (rs)
- `alu_in2` in 32 — operand B (rt or imm32)
- `alu_shamt` in 5 — shift amount
- `alu_calc` in 1 — instruction is an arithmetic op that can trap on overflow
- `alu_ovchk` in 1 — instruction checks overflow (add/addi/sub)
- `alu_load` in 1 — load address calculation
- `alu_store` in 1 — store address calculation
- `alu_out` out 32 — result
- `alu_ov` out 1 — arithmetic overflow exception
- `alu_adel` out 1 — load address-add overflow
- `alu_ades` out 1 — store address-add overflow
- `cmp_a` in 32 — forwarded rs
- `cmp_b` in 32 — forwarded rt
- `cmp_op` in 3 — branch condition
- `cmp_branch` in 1 — instruction is a branch
- `cmp_npcop_in` in 3 — NPC op from decoder
- `cmp_npcop_out` out 3 — NPC op after evaluating the condition
- `cp0_we` in 1 — mtc0 write enable
- `cp0_addr` in 5 — CP0 register number
- `cp0_wdata` in 32 — mtc0 data
- `cp0_rdata` out 32 — mfc0 data
- `cp0_vpc` in 32 — M-stage PC
- `cp0_bd` in 1 — M-stage instruction is in a delay slot
- `cp0_exccode` in 5 — M-stage exception code, 0 = none
- `cp0_hwint` in 6 — external interrupt lines
- `cp0_exlclr` in 1 — eret in M
- `cp0_epc` out 32 — EPC register
- `cp0_req` out 1 — take exception/interrupt this cycle

Behaviour:
ALU (combinational). `alu_op` encoding:
- 0 add
- 1 sub
- 2 or
- 3 and
- 4 lui: `in2<<16`
- 5 slt (signed)
- 6 sltu
- 7 sll: `in2<<shamt`
- 8 srl
- 9 sra
- 10 xor
- 11 nor
- 12 sllv: `in2<<in1[4:0]`
- 13 srlv
- 14 srav
- other values: 0

Overflow flags:
- Overflow is computed on a 33-bit sign-extended add/sub: ov33 = bit32 != bit31 of `{a[31],a} ± {b[31],b}`.
- `alu_ov` = `alu_calc` & `alu_ovchk` & ov33, valid for op 0/1 only.
- `alu_adel` = `alu_load` & ov33(add).
- `alu_ades` = `alu_store` & ov33(add).
- `alu_out` is always the wrapped 32-bit result.

CMP (combinational). `cmp_op` encoding:
- 0 beq: a==b
- 1 bne: a!=b
- 2 blez: signed a<=0
- 3 bgtz: a>0
- 4 bltz: a<0
- 5 bgez: a>=0
- other values: false

`cmp_npcop_out`:
- = 3'b000 (PC+4) when `cmp_branch` & !cond.
- Otherwise = `cmp_npcop_in`; non-branches pass through untouched.

CP0 registers:
- SR (reg 12): IM[15:10], EXL[1], IE[0]; other bits read 0.
- Cause (reg 13): BD[31], IP[15:10], ExcCode[6:2]; read-only to mtc0.
- EPC (reg 14): 32 bits.
- All three reset to 0 asynchronously.

CP0 request logic:
- `int_req` = |(`cp0_hwint` & IM) & IE & !EXL.
- `exc_req` = (`cp0_exccode`!=0) & !EXL.
- `cp0_req` = `int_req` | `exc_req`, combinational.
- Interrupt has priority: recorded ExcCode = 0 when `int_req`, else `cp0_exccode`.

CP0 per posedge, in priority order:
1. If `cp0_req`:
   - EXL<=1
   - BD<=`cp0_bd`
   - ExcCode<=chosen code
   - EPC <= `cp0_bd` ? {`vpc`[31:2],2'b00}-4 : {`vpc`[31:2],2'b00}
   - mtc0 is suppressed in this cycle.
2. Else if `cp0_exlclr`: EXL<=0.
3. mtc0 (`cp0_we` & !`cp0_req`):
   - addr 12 writes IM/EXL/IE from the same bit positions.
   - addr 14 writes EPC.
   - Other addresses are ignored.
   - mtc0 and `exlclr` in the same cycle: mtc0 data wins for SR.
4. IP[15:10] <= `cp0_hwint` every cycle.

CP0 outputs:
- `cp0_rdata`: combinational read of reg 12/13/14, else 0.
- `cp0_epc` = EPC register.

Decomposition:
- Shared package holds:
  - ALU op codes
  - CMP op codes
  - NPC op code PC4 = 3'b000
  - ExcCode constants: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12
  - CP0 register numbers 12/13/14
- One sub-module is natural: `cp0_regs` (all state). ALU and CMP are coded inline as combinational blocks.

Test Plan:
- ALU add 0x7FFFFFFF+1 with calc=ovchk=1 -> `alu_out` 0x80000000, `alu_ov`=1; same operands with `alu_load`=1 -> `alu_adel`=1, `alu_ov`=0.
- ALU sra in2=0x80000000 shamt=4 -> 0xF8000000; sltu 1 vs 0xFFFFFFFF -> 1; slt -> 0.
- CMP bgtz a=0, branch=1, npcop_in=3'b001 -> npcop_out 000; a=5 -> 001; beq a=b=7 -> 001.
- CP0: mtc0 SR=0x0000_0401 (IM[10], IE) then hwint=6'b000001 -> `cp0_req`=1, next cycle Cause.ExcCode=0, EXL=1, EPC=vpc; `req` drops while EXL=1.
- CP0: exccode=12, bd=1, vpc=0x3010 -> EPC=0x300C, Cause=0x80000030; exlclr next cycle -> EXL=0.
- Async reset asserted mid-cycle -> SR/Cause/EPC immediately 0, `cp0_req`=0; mtc0 to addr 13 has no effect.
